pmux_sel: RTL and testbench

- Parameterised parallel (one-hot-select) multiplexer with the semantics of the synthesis `$pmux` cell.
- Output is A when no select bit is set; otherwise it is the B slice chosen by the active select bit.
- Combinational output Y feeds downstream logic directly. A registered copy plus status flags serve pipelined consumers and debug.
- Default configuration (WIDTH=2, S_WIDTH=1) reduces to a 2:1 mux: Y = S ? B : A.

---
 rtl/pmux_sel.sv | 72 +++++++
 tb/tb_pmux_sel.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmux_sel.sv
// pmux_sel: parameterised one-hot-select parallel multiplexer ($pmux semantics).
// Y is combinational; Y_r/hit_r are a registered copy and select status.
// If several select bits are set, the lowest set index wins.
// Optional feature macro: PMUX_CONFLICT_DETECT_EN adds a sticky multi-hot
// "conflict" flag. When the macro is undefined, conflict is tied to 0.
module pmux_sel #(
  parameter int WIDTH   = 2,
  parameter int S_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH*S_WIDTH-1:0] B,
  input  logic [S_WIDTH-1:0]       S,
  output logic [WIDTH-1:0]         Y,
  output logic [WIDTH-1:0]         Y_r,
  output logic                     hit_r,
  output logic                     conflict
);

  // Priority select: scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    Y = A;
    for (int i = S_WIDTH - 1; i >= 0; i--) begin
      if (S[i]) begin
        Y = B[i*WIDTH +: WIDTH];
      end
    end
  end

  // Registered copy of the mux result and of "some select bit was active".
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_r   <= '0;
      hit_r <= 1'b0;
    end else begin
      Y_r   <= Y;
      hit_r <= |S;
    end
  end

`ifdef PMUX_CONFLICT_DETECT_EN
  logic multi_hot;
  logic seen_one;

  // Flag more than one active select bit; a single-bit select can never trip this.
  always_comb begin
    multi_hot = 1'b0;
    seen_one  = 1'b0;
    for (int i = 0; i < S_WIDTH; i++) begin
      if (S[i]) begin
        if (seen_one) begin
          multi_hot = 1'b1;
        end
        seen_one = 1'b1;
      end
    end
  end

  // Sticky conflict flag: once a multi-hot select is seen it holds until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict <= 1'b0;
    end else if (multi_hot) begin
      conflict <= 1'b1;
    end
  end
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_pmux_sel.sv
// tb_pmux_sel: scoreboard-based bench for pmux_sel.
// Two instances: default 2:1 configuration and WIDTH=2, S_WIDTH=3.
module tb_pmux_sel;

`ifdef PMUX_CONFLICT_DETECT_EN
  localparam logic CONF_EN = 1'b1;
`else
  localparam logic CONF_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;

  logic [1:0] a0;
  logic [1:0] b0;
  logic [0:0] s0;
  logic [1:0] y0;
  logic [1:0] y0_r;
  logic       hit0;
  logic       conf0;

  logic [1:0] a1;
  logic [5:0] b1;
  logic [2:0] s1;
  logic [1:0] y1;
  logic [1:0] y1_r;
  logic       hit1;
  logic       conf1;

  int vectors_applied;
  int miscompares;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  pmux_sel dut_default (
    .clk      (clk),
    .rst      (rst),
    .A        (a0),
    .B        (b0),
    .S        (s0),
    .Y        (y0),
    .Y_r      (y0_r),
    .hit_r    (hit0),
    .conflict (conf0)
  );

  pmux_sel #(.WIDTH(2), .S_WIDTH(3)) dut_wide (
    .clk      (clk),
    .rst      (rst),
    .A        (a1),
    .B        (b1),
    .S        (s1),
    .Y        (y1),
    .Y_r      (y1_r),
    .hit_r    (hit1),
    .conflict (conf1)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference pmux: first (lowest) set select bit picks its slice, else A.
  function automatic logic [1:0] pmuxModel(input logic [1:0] a, input logic [5:0] b,
                                           input logic [2:0] s, input int sw);
    logic [1:0] r;
    logic       found;
    r = a;
    found = 1'b0;
    for (int i = 0; i < sw; i++) begin
      if (s[i] && !found) begin
        r = b[i*2 +: 2];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [7:0] expected);
    tag_q.push_back(tag);
    exp_q.push_back(expected);
  endtask

  task automatic popCheck(input logic [7:0] actual);
    string      tag;
    logic [7:0] expected;
    if (exp_q.size() == 0) begin
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got %0h, expected an entry", actual);
    end else begin
      tag = tag_q.pop_front();
      expected = exp_q.pop_front();
      checkOutput(tag, actual, expected);
    end
  endtask

  // Drive the default instance combinationally and check Y after settling.
  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic s);
    a0 = a;
    b0 = b;
    s0 = s;
    pushExpect($sformatf("y0_a%0h_b%0h_s%0h", a, b, s), {6'd0, pmuxModel(a, {4'd0, b}, {2'd0, s}, 1)});
    #1;
    popCheck({6'd0, y0});
  endtask

  task automatic applyWide(input logic [1:0] a, input logic [5:0] b, input logic [2:0] s);
    a1 = a;
    b1 = b;
    s1 = s;
    pushExpect($sformatf("y1_s%0b", s), {6'd0, pmuxModel(a, b, s, 3)});
    #1;
    popCheck({6'd0, y1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] a_list [4];
    logic [1:0] b_list [3];
    vectors_applied = 0;
    miscompares = 0;
    rst = 1'b0;
    a0 = 2'b00; b0 = 2'b00; s0 = 1'b0;
    a1 = 2'b00; b1 = 6'b0;  s1 = 3'b000;
    a_list = '{2'b00, 2'b01, 2'b11, 2'b10};
    b_list = '{2'b00, 2'b10, 2'b11};

    // Combinational sweep, default params, both select values.
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 3; bi++) begin
        applyStimulus(a_list[ai], b_list[bi], 1'b1);
        applyStimulus(a_list[ai], b_list[bi], 1'b0);
      end
    end

    // Wide instance, B = {11,10,01} for slices 2..0.
    applyWide(2'b00, 6'b11_10_01, 3'b010);
    applyWide(2'b00, 6'b11_10_01, 3'b100);
    applyWide(2'b00, 6'b11_10_01, 3'b000);
    applyWide(2'b00, 6'b11_10_01, 3'b110);
    applyWide(2'b10, 6'b11_10_01, 3'b111);
    applyWide(2'b10, 6'b11_10_01, 3'b000);

    // Reset for two edges.
    rst = 1'b1;
    @(posedge clk);
    tick();
    pushExpect("y0_r_reset", 8'h00);
    pushExpect("hit0_reset", 8'h00);
    pushExpect("conf0_reset", 8'h00);
    pushExpect("y1_r_reset", 8'h00);
    pushExpect("conf1_reset", 8'h00);
    popCheck({6'd0, y0_r});
    popCheck({7'd0, hit0});
    popCheck({7'd0, conf0});
    popCheck({6'd0, y1_r});
    popCheck({7'd0, conf1});

    // Registered path, default instance.
    rst = 1'b0;
    s0 = 1'b1; b0 = 2'b10;
    pushExpect("y0_r_sel", 8'h02);
    pushExpect("hit0_sel", 8'h01);
    tick();
    popCheck({6'd0, y0_r});
    popCheck({7'd0, hit0});

    s0 = 1'b0; a0 = 2'b01;
    pushExpect("y0_r_dflt", 8'h01);
    pushExpect("hit0_dflt", 8'h00);
    tick();
    popCheck({6'd0, y0_r});
    popCheck({7'd0, hit0});

    s0 = 1'b1; b0 = 2'b11;
    pushExpect("y0_r_11", 8'h03);
    pushExpect("hit0_11", 8'h01);
    tick();
    popCheck({6'd0, y0_r});
    popCheck({7'd0, hit0});

    // Mid-run reset pulse: registers clear, Y keeps tracking.
    rst = 1'b1;
    pushExpect("y0_r_midrst", 8'h00);
    pushExpect("hit0_midrst", 8'h00);
    pushExpect("y0_during_rst", 8'h03);
    tick();
    popCheck({6'd0, y0_r});
    popCheck({7'd0, hit0});
    popCheck({6'd0, y0});
    b0 = 2'b10;
    pushExpect("y0_tracks_in_rst", 8'h02);
    #1;
    popCheck({6'd0, y0});
    rst = 1'b0;

    // Conflict flag on the wide instance.
    a1 = 2'b00; b1 = 6'b11_10_01; s1 = 3'b011;
    pushExpect("y1_multi", 8'h01);
    #1;
    popCheck({6'd0, y1});
    pushExpect("conf1_set", {7'd0, CONF_EN});
    pushExpect("hit1_multi", 8'h01);
    pushExpect("y1_r_multi", 8'h01);
    tick();
    popCheck({7'd0, conf1});
    popCheck({7'd0, hit1});
    popCheck({6'd0, y1_r});

    s1 = 3'b001;
    pushExpect("conf1_sticky", {7'd0, CONF_EN});
    tick();
    popCheck({7'd0, conf1});
    s1 = 3'b000;
    pushExpect("conf1_sticky2", {7'd0, CONF_EN});
    pushExpect("hit1_none", 8'h00);
    tick();
    popCheck({7'd0, conf1});
    popCheck({7'd0, hit1});

    rst = 1'b1;
    pushExpect("conf1_cleared", 8'h00);
    pushExpect("conf0_never", 8'h00);
    tick();
    popCheck({7'd0, conf1});
    popCheck({7'd0, conf0});
    rst = 1'b0;

    if (exp_q.size() != 0) begin
      vectors_applied++;
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
